// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver.
// 5-8 data bits, none/even/odd parity, 1 or 2 stop bits, programmable
// oversample divider. Each bit is resolved by a 3-sample majority vote at
// mid-bit. Character, parity/framing errors and break are reported together
// on a single-cycle data_valid pulse and held until the next one.
module uart_rx_cfg #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_input,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic [1:0]           data_bits,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic [7:0]           byte_data,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0]        S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0]        S_A     = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0]        S_B     = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0]        S_C     = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0]        S_ZERO  = {SW{1'b0}};
  localparam logic [SW-1:0]        S_ONE   = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  // Parity over the assembled character; upper unused bits are always 0.
  function automatic logic parity_calc(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Two-of-three majority.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t                 state_r, state_nxt;
  logic                   rx_meta_r, rx_sync_r, rx_prev_r;
  logic                   rx_s, fall_s;
  logic [DIV_WIDTH-1:0]   div_cnt_r, div_lat_r;
  logic                   tick_s;
  logic [SW-1:0]          s_cnt_r;
  logic                   samp_a_r, samp_b_r;
  logic                   vote_s, decide_s;
  logic [1:0]             nbits_lat_r, pmode_lat_r;
  logic                   two_stop_lat_r, par_en_s;
  logic [2:0]             bit_idx_r, last_idx_s;
  logic [7:0]             shift_r;
  logic                   zero_r, par_err_r, frm_r, brk_r;
  logic                   start_s, store_s, par_chk_s, stop1_s, stop2_s, finish_s;
  logic                   frm_now_s, brk_now_s;
  logic                   busy_r;

  assign rx_s       = rx_sync_r;
  assign fall_s     = rx_prev_r & ~rx_s;
  assign tick_s     = (div_cnt_r == div_lat_r);
  assign vote_s     = majority3(samp_a_r, samp_b_r, rx_s);
  assign decide_s   = tick_s && (s_cnt_r == S_C) && (state_r != IDLE);
  assign par_en_s   = (pmode_lat_r == 2'd1) || (pmode_lat_r == 2'd2);
  assign last_idx_s = 3'd4 + {1'b0, nbits_lat_r};
  assign busy       = busy_r;

  // Two-flop synchroniser plus previous-value flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_input;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Next-state logic and per-decision control strobes.
  always_comb begin
    state_nxt = state_r;
    start_s   = 1'b0;
    store_s   = 1'b0;
    par_chk_s = 1'b0;
    stop1_s   = 1'b0;
    stop2_s   = 1'b0;
    finish_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s) begin
          state_nxt = START;
          start_s   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (decide_s) begin
          if (!vote_s) begin
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = START;
        end
      end
      DATA: begin
        if (decide_s) begin
          store_s = 1'b1;
          if (bit_idx_r == last_idx_s) begin
            if (par_en_s) begin
              state_nxt = PARITY;
            end else begin
              state_nxt = STOP1;
            end
          end else begin
            state_nxt = DATA;
          end
        end else begin
          state_nxt = DATA;
        end
      end
      PARITY: begin
        if (decide_s) begin
          par_chk_s = 1'b1;
          state_nxt = STOP1;
        end else begin
          state_nxt = PARITY;
        end
      end
      STOP1: begin
        if (decide_s) begin
          stop1_s = 1'b1;
          if (two_stop_lat_r) begin
            state_nxt = STOP2;
          end else begin
            state_nxt = IDLE;
            finish_s  = 1'b1;
          end
        end else begin
          state_nxt = STOP1;
        end
      end
      STOP2: begin
        if (decide_s) begin
          stop2_s   = 1'b1;
          finish_s  = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = STOP2;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Final flag values including the stop bit being decided this cycle.
  always_comb begin
    frm_now_s = frm_r;
    brk_now_s = brk_r;
    if (stop1_s) begin
      frm_now_s = ~vote_s;
      brk_now_s = zero_r & ~vote_s;
    end else if (stop2_s) begin
      frm_now_s = frm_r | ~vote_s;
      brk_now_s = brk_r;
    end else begin
      frm_now_s = frm_r;
      brk_now_s = brk_r;
    end
  end

  // State register; busy mirrors "not IDLE" as a registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt;
      busy_r  <= (state_nxt != IDLE);
    end
  end

  // Oversample tick divider; held at zero while idle so a start edge restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= DIV_ZERO;
    end else if (state_r == IDLE) begin
      div_cnt_r <= DIV_ZERO;
    end else if (tick_s) begin
      div_cnt_r <= DIV_ZERO;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

  // Sample position within the bit and the first two mid-bit samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt_r  <= S_ZERO;
      samp_a_r <= 1'b0;
      samp_b_r <= 1'b0;
    end else if (state_r == IDLE) begin
      s_cnt_r  <= S_ZERO;
    end else if (tick_s) begin
      s_cnt_r <= (s_cnt_r == S_LAST) ? S_ZERO : (s_cnt_r + S_ONE);
      if (s_cnt_r == S_A) begin
        samp_a_r <= rx_s;
      end
      if (s_cnt_r == S_B) begin
        samp_b_r <= rx_s;
      end
    end
  end

  // Frame configuration is captured at start detection and held for the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_lat_r      <= DIV_ZERO;
      nbits_lat_r    <= 2'd0;
      pmode_lat_r    <= 2'd0;
      two_stop_lat_r <= 1'b0;
    end else if (start_s) begin
      div_lat_r      <= baud_div;
      nbits_lat_r    <= data_bits;
      pmode_lat_r    <= parity_mode;
      two_stop_lat_r <= two_stop;
    end
  end

  // Character assembly and error accumulation across the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      zero_r    <= 1'b0;
      par_err_r <= 1'b0;
      frm_r     <= 1'b0;
      brk_r     <= 1'b0;
    end else if (start_s) begin
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      zero_r    <= 1'b1;
      par_err_r <= 1'b0;
      frm_r     <= 1'b0;
      brk_r     <= 1'b0;
    end else if (store_s) begin
      shift_r[bit_idx_r] <= vote_s;
      bit_idx_r          <= bit_idx_r + 3'd1;
      zero_r             <= zero_r & ~vote_s;
    end else if (par_chk_s) begin
      par_err_r <= (vote_s != parity_calc(shift_r, pmode_lat_r == 2'd2));
      zero_r    <= zero_r & ~vote_s;
    end else if (stop1_s || stop2_s) begin
      frm_r <= frm_now_s;
      brk_r <= brk_now_s;
    end
  end

  // Registered character outputs; updated only when a frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      byte_data  <= 8'h00;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      data_valid <= finish_s;
      if (finish_s) begin
        byte_data  <= shift_r;
        parity_err <= par_err_r;
        frame_err  <= frm_now_s;
        break_det  <= brk_now_s;
      end
    end
  end

endmodule
